rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter PHASE_CYC, default 4, meaning clock cycles per bus phase; legal range 1..16.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_wr  input  1  single-cycle request for a write transaction.
REQ-005 start_rd  input  1  single-cycle request for a read transaction.
REQ-006 addr  input  8  RTC register address.
REQ-007 wr_data  input  8  write payload.
REQ-008 ad_in  input  8  value sampled from the multiplexed AD bus pins.
REQ-009 sel  output  1  select for the downstream data mux: 0 = latched address, 1 = latched write data.
REQ-010 addr_q  output  8  latched address, feeds mux input data_a.
REQ-011 data_q  output  8  latched write data, feeds mux input data_b.
REQ-012 ad_oe  output  1  AD bus tristate drive enable, 1 = FPGA drives.
REQ-013 cs_n, ad_n, wr_n, rd_n  output  1 each  active-low chip select, address strobe, write strobe and read strobe.
REQ-014 rd_data  output  8  data captured during a read.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 FSM states SHALL be IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD and DONE.
REQ-019 Each state A_SET through D_HLD SHALL last exactly PHASE_CYC cycles, timed by a 4-bit phase counter that reloads on every state change.
REQ-020 In IDLE, start_wr or start_rd sampled high SHALL latch addr, wr_data and the operation type, then enter A_SET.
REQ-021 If start_wr and start_rd are high in the same cycle, the write SHALL win.
REQ-022 start_wr and start_rd SHALL be ignored while busy=1, with no queuing.
REQ-023 Outputs per state (unlisted signals at idle levels: cs_n, ad_n, wr_n, rd_n = 1; ad_oe = 0; sel = 0):
  IDLE: all idle levels; busy = 0.
  A_SET: cs_n = 0, ad_n = 0, ad_oe = 1, sel = 0.
  A_STB: as A_SET, plus wr_n = 0.
  A_HLD: as A_SET.
  D_SET: cs_n = 0, sel = 1, ad_oe = 1 for a write, 0 for a read.
  D_STB, write: as D_SET, plus wr_n = 0.
  D_STB, read: cs_n = 0, sel = 1, rd_n = 0, ad_oe = 0.
  D_HLD: as D_SET.
  DONE: all idle levels, done = 1, busy = 1.
REQ-024 For a read, rd_data SHALL load ad_in on the final cycle of D_STB, and SHALL otherwise hold its value until the next read or reset.
REQ-025 DONE SHALL last one cycle, then the FSM SHALL return to IDLE.
REQ-026 A start may be accepted in the IDLE cycle that immediately follows DONE.
REQ-027 Latency: for a start sampled at edge 0, done SHALL be high in cycle 6*PHASE_CYC+1; this is cycle 25 at the default PHASE_CYC.
REQ-028 ad_oe SHALL never be 1 while rd_n = 0.
REQ-029 wr_n and rd_n SHALL never be low in the same cycle.

Reset
REQ-030 Reset SHALL be sampled only on a rising clk edge and SHALL override all other inputs.
REQ-031 Reset SHALL force the following on the next edge, including mid-transaction: FSM to IDLE, phase counter = 0, cs_n = ad_n = wr_n = rd_n = 1, ad_oe = 0, sel = 0, busy = 0, done = 0, addr_q = data_q = rd_data = 8'h00.
REQ-032 A start asserted in the same cycle as reset SHALL be discarded.

Verification
REQ-033 Write, PHASE_CYC = 4: start_wr with addr = 8'h21 and wr_data = 8'h59 -> the following SHALL hold:
  - wr_n low in cycles 5-8 with sel = 0 and ad_n = 0;
  - wr_n low in cycles 17-20 with sel = 1 and ad_oe = 1;
  - done high in cycle 25 only.
REQ-034 Read: start_rd with addr = 8'h22 and ad_in = 8'hA7 during D_STB -> rd_n low in cycles 17-20 with ad_oe = 0, and rd_data = 8'hA7 from cycle 21.
REQ-035 Simultaneous start_wr and start_rd -> a write cycle results and rd_n stays high throughout.
REQ-036 start_rd pulsed in cycle 10 of an active write -> the pulse is ignored, exactly one done results, and busy falls in cycle 26.
REQ-037 Reset asserted in cycle 18 of a write -> from cycle 19 all strobes are high, ad_oe = 0, busy = 0 and rd_data = 8'h00, with no done pulse.
REQ-038 PHASE_CYC = 1: back-to-back writes with start re-asserted in the IDLE cycle after DONE -> done pulses 8 cycles apart.

Source files
------------

// File: rtl/rtc_bus_if.sv
// Request/response bundle between a host and the RTC multiplexed-bus controller.
interface rtc_bus_if;
  logic       start_wr;
  logic       start_rd;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] ad_in;
  logic       sel;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  modport master (
    output start_wr, start_rd, addr, wr_data, ad_in,
    input  sel, addr_q, data_q, ad_oe, cs_n, ad_n, wr_n, rd_n, rd_data, busy, done
  );

  modport slave (
    input  start_wr, start_rd, addr, wr_data, ad_in,
    output sel, addr_q, data_q, ad_oe, cs_n, ad_n, wr_n, rd_n, rd_data, busy, done
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Sequencer for a multiplexed address/data RTC bus: address phase, data phase, done pulse.
// Every state except IDLE/DONE lasts PHASE_CYC cycles; all outputs are flops.
module rtc_bus_ctrl #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic     clk,
  input  logic     reset,
  rtc_bus_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DAT_W = 8;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_rd_q, is_rd_d;
  logic [DAT_W-1:0]   addr_lat_q, addr_lat_d;
  logic [DAT_W-1:0]   data_lat_q, data_lat_d;
  logic [DAT_W-1:0]   rd_data_q, rd_data_d;
  logic               sel_q, sel_d;
  logic               ad_oe_q, ad_oe_d;
  logic               cs_n_q, cs_n_d;
  logic               ad_n_q, ad_n_d;
  logic               wr_n_q, wr_n_d;
  logic               rd_n_q, rd_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State register and all output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      addr_lat_q <= '0;
      data_lat_q <= '0;
      rd_data_q  <= '0;
      sel_q      <= 1'b0;
      ad_oe_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      addr_lat_q <= addr_lat_d;
      data_lat_q <= data_lat_d;
      rd_data_q  <= rd_data_d;
      sel_q      <= sel_d;
      ad_oe_q    <= ad_oe_d;
      cs_n_q     <= cs_n_d;
      ad_n_q     <= ad_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, phase timing, request latching and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    addr_lat_d = addr_lat_q;
    data_lat_d = data_lat_q;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_wr || bus.start_rd) begin
          state_d    = A_SET;
          cnt_d      = RELOAD;
          is_rd_d    = ~bus.start_wr;
          addr_lat_d = bus.addr;
          data_lat_d = bus.wr_data;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          unique case (state_q)
            A_SET:   state_d = A_STB;
            A_STB:   state_d = A_HLD;
            A_HLD:   state_d = D_SET;
            D_SET:   state_d = D_STB;
            D_STB:   state_d = D_HLD;
            default: begin
              state_d = DONE;
              cnt_d   = '0;
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    // Sample the bus on the last cycle of the read strobe
    if (state_q == D_STB && is_rd_q && cnt_q == '0) begin
      rd_data_d = bus.ad_in;
    end
  end

  // Output decode from the upcoming state so the registered pins line up with it
  always_comb begin
    sel_d   = 1'b0;
    ad_oe_d = 1'b0;
    cs_n_d  = 1'b1;
    ad_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    busy_d  = (state_d != IDLE);
    done_d  = 1'b0;
    unique case (state_d)
      A_SET, A_HLD: begin
        cs_n_d  = 1'b0;
        ad_n_d  = 1'b0;
        ad_oe_d = 1'b1;
      end
      A_STB: begin
        cs_n_d  = 1'b0;
        ad_n_d  = 1'b0;
        ad_oe_d = 1'b1;
        wr_n_d  = 1'b0;
      end
      D_SET, D_HLD: begin
        cs_n_d  = 1'b0;
        sel_d   = 1'b1;
        ad_oe_d = ~is_rd_d;
      end
      D_STB: begin
        cs_n_d = 1'b0;
        sel_d  = 1'b1;
        if (is_rd_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d  = 1'b0;
          ad_oe_d = 1'b1;
        end
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.sel     = sel_q;
  assign bus.addr_q  = addr_lat_q;
  assign bus.data_q  = data_lat_q;
  assign bus.ad_oe   = ad_oe_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.ad_n    = ad_n_q;
  assign bus.wr_n    = wr_n_q;
  assign bus.rd_n    = rd_n_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: two instances (PHASE_CYC 4 and 1) checked every cycle against a
// transaction-timeline model, plus directed scenarios with hand-computed literal expectations.
module tb_rtc_bus_ctrl;

  localparam int unsigned PC0 = 4;
  localparam int unsigned PC1 = 1;

  logic clk = 1'b0;
  logic reset;
  logic armed = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sw, sr;
  logic [7:0] ad [2];
  logic [7:0] wd [2];
  logic [7:0] ain [2];

  rtc_bus_if if0();
  rtc_bus_if if1();

  assign if0.start_wr = sw[0];
  assign if0.start_rd = sr[0];
  assign if0.addr     = ad[0];
  assign if0.wr_data  = wd[0];
  assign if0.ad_in    = ain[0];
  assign if1.start_wr = sw[1];
  assign if1.start_rd = sr[1];
  assign if1.addr     = ad[1];
  assign if1.wr_data  = wd[1];
  assign if1.ad_in    = ain[1];

  rtc_bus_ctrl #(.PHASE_CYC(PC0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  rtc_bus_ctrl #(.PHASE_CYC(PC1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // {sel, ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done, addr_q, data_q, rd_data}
  logic [31:0] obs [2];
  assign obs[0] = {if0.sel, if0.ad_oe, if0.cs_n, if0.ad_n, if0.wr_n, if0.rd_n, if0.busy, if0.done,
                   if0.addr_q, if0.data_q, if0.rd_data};
  assign obs[1] = {if1.sel, if1.ad_oe, if1.cs_n, if1.ad_n, if1.wr_n, if1.rd_n, if1.busy, if1.done,
                   if1.addr_q, if1.data_q, if1.rd_data};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    check(name, 32'(act), 32'(req));
  endtask

  function automatic int pcf(input int k);
    return (k == 0) ? int'(PC0) : int'(PC1);
  endfunction

  // Expected pin levels from position within a transaction (0 = idle)
  function automatic logic [7:0] exp_ctrl(input int rel, input int p, input logic rd);
    logic sel, oe, cs, adn, wr, rdn, bsy, dn;
    int ph;
    sel = 1'b0; oe = 1'b0; cs = 1'b1; adn = 1'b1; wr = 1'b1; rdn = 1'b1;
    bsy = (rel != 0);
    dn  = (rel == 6 * p + 1);
    if (rel >= 1 && rel <= 6 * p) begin
      ph = (rel - 1) / p;
      cs = 1'b0;
      if (ph < 3) begin
        adn = 1'b0;
        oe  = 1'b1;
        wr  = (ph != 1);
      end else begin
        sel = 1'b1;
        oe  = ~rd;
        if (ph == 4) begin
          if (rd) rdn = 1'b0;
          else begin
            wr = 1'b0;
            oe = 1'b1;
          end
        end
      end
    end
    return {sel, oe, cs, adn, wr, rdn, bsy, dn};
  endfunction

  int         m_rel  [2];
  logic       m_rd   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] m_rdd  [2];

  // Transaction model: m_rel counts cycles since the accepting edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_rel[k]  <= 0;
        m_rd[k]   <= 1'b0;
        m_addr[k] <= 8'h00;
        m_data[k] <= 8'h00;
        m_rdd[k]  <= 8'h00;
      end else if (m_rel[k] == 0) begin
        if (sw[k] || sr[k]) begin
          m_rel[k]  <= 1;
          m_rd[k]   <= ~sw[k];
          m_addr[k] <= ad[k];
          m_data[k] <= wd[k];
        end
      end else begin
        if (m_rd[k] && m_rel[k] == 5 * pcf(k)) m_rdd[k] <= ain[k];
        m_rel[k] <= (m_rel[k] == 6 * pcf(k) + 1) ? 0 : m_rel[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] e;
        e = {exp_ctrl(m_rel[k], pcf(k), m_rd[k]), m_addr[k], m_data[k], m_rdd[k]};
        check($sformatf("dut%0d_ctrl", k), 32'(obs[k][31:24]), 32'(e[31:24]));
        check($sformatf("dut%0d_addr_q", k), 32'(obs[k][23:16]), 32'(e[23:16]));
        check($sformatf("dut%0d_data_q", k), 32'(obs[k][15:8]), 32'(e[15:8]));
        check($sformatf("dut%0d_rd_data", k), 32'(obs[k][7:0]), 32'(e[7:0]));
        chk1($sformatf("dut%0d_oe_with_rd", k), obs[k][30] & ~obs[k][26], 1'b0);
        chk1($sformatf("dut%0d_wr_rd_overlap", k), ~obs[k][27] & ~obs[k][26], 1'b0);
      end
    end
  end

  // Present a start for one cycle; returns #1 into cycle 1 of the transaction
  task automatic go(input int k, input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    sw[k] = w;
    sr[k] = r;
    ad[k] = a;
    wd[k] = d;
    @(posedge clk);
    #1;
    sw[k] = 1'b0;
    sr[k] = 1'b0;
  endtask

  int ndone;

  initial begin
    reset = 1'b1;
    sw = '0;
    sr = '0;
    for (int k = 0; k < 2; k++) begin
      ad[k] = 8'h00; wd[k] = 8'h00; ain[k] = 8'h00;
    end
    @(posedge clk);
    #1 armed = 1'b1;
    sw[0] = 1'b1;
    sr[1] = 1'b1;
    @(negedge clk);
    chk1("rst_busy", if0.busy, 1'b0);
    chk1("rst_cs_n", if0.cs_n, 1'b1);
    check("rst_rd_data", 32'(if0.rd_data), 32'h00);
    @(posedge clk);
    #1;
    sw = '0;
    sr = '0;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_start_dropped0", if0.busy, 1'b0);
    chk1("rst_start_dropped1", if1.busy, 1'b0);
    @(posedge clk);
    #1;

    // Write 0x59 to 0x21
    go(0, 1'b1, 1'b0, 8'h21, 8'h59);
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t1_addr_q", 32'(if0.addr_q), 32'h21);
        check("t1_data_q", 32'(if0.data_q), 32'h59);
      end
      if (n >= 5 && n <= 8) begin
        chk1("t1_a_wr_n", if0.wr_n, 1'b0);
        chk1("t1_a_sel", if0.sel, 1'b0);
        chk1("t1_a_ad_n", if0.ad_n, 1'b0);
      end
      if (n >= 17 && n <= 20) begin
        chk1("t1_d_wr_n", if0.wr_n, 1'b0);
        chk1("t1_d_sel", if0.sel, 1'b1);
        chk1("t1_d_ad_oe", if0.ad_oe, 1'b1);
      end
      chk1("t1_done", if0.done, n == 25);
      if (n == 26) chk1("t1_busy_off", if0.busy, 1'b0);
      @(posedge clk);
      #1;
    end

    // Read from 0x22; bus shows 0xA7 only during the read strobe
    ain[0] = 8'h3C;
    go(0, 1'b0, 1'b1, 8'h22, 8'h00);
    for (int n = 1; n <= 27; n++) begin
      ain[0] = (n >= 17 && n <= 20) ? 8'hA7 : 8'h3C;
      @(negedge clk);
      if (n >= 17 && n <= 20) begin
        chk1("t2_rd_n", if0.rd_n, 1'b0);
        chk1("t2_ad_oe", if0.ad_oe, 1'b0);
        chk1("t2_wr_n", if0.wr_n, 1'b1);
      end
      if (n == 20) check("t2_rd_data_early", 32'(if0.rd_data), 32'h00);
      if (n >= 21) check("t2_rd_data", 32'(if0.rd_data), 32'hA7);
      chk1("t2_done", if0.done, n == 25);
      @(posedge clk);
      #1;
    end

    // Simultaneous write and read requests: write wins
    go(0, 1'b1, 1'b1, 8'h30, 8'hC3);
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      chk1("t3_rd_n", if0.rd_n, 1'b1);
      if ((n >= 5 && n <= 8) || (n >= 17 && n <= 20)) chk1("t3_wr_n", if0.wr_n, 1'b0);
      if (n >= 17 && n <= 20) chk1("t3_ad_oe", if0.ad_oe, 1'b1);
      chk1("t3_done", if0.done, n == 25);
      @(posedge clk);
      #1;
    end

    // Read request in cycle 10 of a write is dropped
    ndone = 0;
    go(0, 1'b1, 1'b0, 8'h40, 8'h11);
    for (int n = 1; n <= 30; n++) begin
      sr[0] = (n == 10);
      ad[0] = (n == 10) ? 8'h55 : 8'h40;
      @(negedge clk);
      if (if0.done) ndone++;
      if (n == 12) check("t4_addr_kept", 32'(if0.addr_q), 32'h40);
      if (n == 25) chk1("t4_busy_25", if0.busy, 1'b1);
      if (n == 26) chk1("t4_busy_26", if0.busy, 1'b0);
      if (n == 30) check("t4_rd_data_kept", 32'(if0.rd_data), 32'hA7);
      @(posedge clk);
      #1;
    end
    check("t4_done_count", 32'(ndone), 32'd1);

    // Reset in cycle 18 of a write, with a read request in the same cycle
    go(0, 1'b1, 1'b0, 8'h66, 8'h77);
    for (int n = 1; n <= 30; n++) begin
      reset = (n == 18);
      sr[0] = (n == 18);
      @(negedge clk);
      if (n == 17) chk1("t5_wr_n_pre", if0.wr_n, 1'b0);
      if (n >= 19) begin
        chk1("t5_wr_n", if0.wr_n, 1'b1);
        chk1("t5_rd_n", if0.rd_n, 1'b1);
        chk1("t5_cs_n", if0.cs_n, 1'b1);
        chk1("t5_ad_n", if0.ad_n, 1'b1);
        chk1("t5_ad_oe", if0.ad_oe, 1'b0);
        chk1("t5_busy", if0.busy, 1'b0);
        chk1("t5_done", if0.done, 1'b0);
        check("t5_rd_data", 32'(if0.rd_data), 32'h00);
        check("t5_addr_q", 32'(if0.addr_q), 32'h00);
      end
      @(posedge clk);
      #1;
    end

    // PHASE_CYC=1 back-to-back writes, second start in the IDLE cycle after DONE
    go(1, 1'b1, 1'b0, 8'h12, 8'h34);
    for (int n = 1; n <= 18; n++) begin
      sw[1] = (n == 8);
      ad[1] = 8'h56;
      wd[1] = 8'h78;
      @(negedge clk);
      chk1("t6_done", if1.done, (n == 7) || (n == 15));
      if (n == 8) chk1("t6_idle_gap", if1.busy, 1'b0);
      if (n == 9) check("t6_addr_q", 32'(if1.addr_q), 32'h56);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
